program_sequencer: RTL and testbench

//  Fetch/decode/issue sequencer for the 8-bit processor. Fetches instruction bytes from

---
 rtl/program_sequencer_pkg.sv | 32 +++
 rtl/program_sequencer.sv | 132 +++++++++++++
 tb/tb_program_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared opcode map and sequencer state encoding for the 8-bit processor.
// The ALU controller imports the same package.
package program_sequencer_pkg;

    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpSub = 4'h1;
    localparam logic [3:0] OpAnd = 4'h2;
    localparam logic [3:0] OpOr  = 4'h3;
    localparam logic [3:0] OpXor = 4'h4;
    localparam logic [3:0] OpNot = 4'h5;
    localparam logic [3:0] OpInc = 4'h6;
    localparam logic [3:0] OpShl = 4'h7;
    localparam logic [3:0] OpShr = 4'h8;
    localparam logic [3:0] OpJmp = 4'h9;
    localparam logic [3:0] OpJz  = 4'hA;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWait,
        StFetchAddr,
        StHalt
    } seq_state_e;

    function automatic logic is_alu_op(input logic [3:0] opc);
        return opc <= OpShr;
    endfunction

endpackage

// File: rtl/program_sequencer.sv
// Fetch/decode/issue sequencer: fetches instruction bytes over req/ack, resolves
// JMP/JZ/HLT locally and hands ALU opcodes to the controller as a one-cycle strobe.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned EXEC_CYCLES = 3,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    input  logic              zero_flag,
    output logic [3:0]        opcode,
    output logic              op,
    output logic [3:0]        operand,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    localparam int unsigned CntW = (EXEC_CYCLES > 2) ? $clog2(EXEC_CYCLES) : 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [3:0]        operand_q, operand_d;
    logic [3:0]        ir_opc;

    assign ir_opc = ir_q[7:4];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= '0;
            cnt_q     <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        mem_req   = 1'b0;
        op        = 1'b0;
        illegal   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_alu_op(ir_opc)) begin
                    // Loaded here so the new value is visible exactly in the issue cycle.
                    opcode_d  = ir_opc;
                    operand_d = ir_q[3:0];
                    state_d   = StIssue;
                end else if (ir_opc == OpJmp || ir_opc == OpJz) begin
                    state_d = StFetchAddr;
                end else if (ir_opc == OpHlt) begin
                    state_d = StHalt;
                end else begin
                    illegal = 1'b1;
                    state_d = StFetch;
                end
            end
            StIssue: begin
                op = 1'b1;
                if (EXEC_CYCLES == 1) begin
                    state_d = StFetch;
                end else begin
                    cnt_d   = CntW'(EXEC_CYCLES - 2);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) state_d = StFetch;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StFetchAddr: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (ir_opc == OpJmp || zero_flag) pc_d = ADDR_W'(mem_rdata);
                    else                              pc_d = pc_q + ADDR_W'(1);
                    state_d = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_addr = mem_req ? pc_q : '0;
    assign opcode   = opcode_q;
    assign operand  = operand_q;
    assign pc       = pc_q;
    assign busy     = (state_q != StIdle) && (state_q != StHalt);
    assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer: a cycle-timed instruction-level reference
// model runs alongside the DUT, plus directed programs for jumps, wrap and reset.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    localparam int ExecCycles = 3;
    localparam int Never      = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       zero_flag = 1'b0;
    logic       mem_req, op, busy, halted, illegal;
    logic [7:0] mem_addr, pc;
    logic [3:0] opcode, operand;

    program_sequencer #(
        .ADDR_W      (8),
        .EXEC_CYCLES (ExecCycles),
        .RESET_PC    (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .zero_flag (zero_flag),
        .opcode    (opcode),
        .op        (op),
        .operand   (operand),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] mem [256];
    int ack_pct   = 100;
    int ack_delay = -1;
    int zf_mode   = 2;
    int wait_n    = 0;

    // Memory responder: random or fixed ack latency, plus spurious acks with no request.
    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            if (ack_delay < 0) mem_ack = ($urandom_range(0, 99) < ack_pct);
            else               mem_ack = (wait_n >= ack_delay);
            mem_rdata = mem_ack ? mem[mem_addr] : 8'($urandom);
            wait_n    = mem_ack ? 0 : wait_n + 1;
        end else begin
            mem_ack   = ($urandom_range(0, 7) == 0);
            mem_rdata = 8'($urandom);
            wait_n    = 0;
        end
        zero_flag = (zf_mode == 2) ? 1'($urandom) : 1'(zf_mode);
    end

    // Reference model state: program-level position plus the cycle each event is due.
    bit         mon_en = 1'b0;
    int         cyc;
    bit         m_started, m_addr_phase, m_is_jz;
    logic [7:0] m_pc;
    int         m_req_cyc, m_op_cyc, m_ill_cyc, m_halt_cyc, m_start_cyc;
    logic [3:0] m_exp_opc, m_exp_opd, m_last_opc, m_last_opd;
    logic [7:0] ops_q[$];
    int         op_cyc_q[$];
    logic [7:0] addr_q[$];
    int         n_ill;

    task automatic model_reset();
        cyc          = 0;
        m_started    = 1'b0;
        m_addr_phase = 1'b0;
        m_is_jz      = 1'b0;
        m_pc         = 8'h00;
        m_req_cyc    = Never;
        m_op_cyc     = Never;
        m_ill_cyc    = Never;
        m_halt_cyc   = Never;
        m_start_cyc  = Never;
        m_last_opc   = 4'h0;
        m_last_opd   = 4'h0;
        ops_q.delete();
        op_cyc_q.delete();
        addr_q.delete();
        n_ill = 0;
    endtask

    bit         exp_req, exp_halt;
    logic [7:0] b;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            exp_req  = (cyc >= m_req_cyc);
            exp_halt = (cyc >= m_halt_cyc);
            check("mem_req", 32'(mem_req), 32'(exp_req));
            if (mem_req === 1'b1) check("mem_addr", 32'(mem_addr), 32'(m_pc));
            check("pc", 32'(pc), 32'(m_pc));
            check("op", 32'(op), 32'(cyc == m_op_cyc));
            if (cyc == m_op_cyc) begin
                m_last_opc = m_exp_opc;
                m_last_opd = m_exp_opd;
            end
            check("opcode", 32'(opcode), 32'(m_last_opc));
            check("operand", 32'(operand), 32'(m_last_opd));
            check("illegal", 32'(illegal), 32'(cyc == m_ill_cyc));
            check("halted", 32'(halted), 32'(exp_halt));
            check("busy", 32'(busy), 32'(cyc >= m_start_cyc && !exp_halt));

            if (op === 1'b1) begin
                ops_q.push_back({opcode, operand});
                op_cyc_q.push_back(cyc);
            end
            if (illegal === 1'b1) n_ill++;
            if (mem_req === 1'b1 && mem_ack) addr_q.push_back(mem_addr);

            if (!m_started && start) begin
                m_started   = 1'b1;
                m_start_cyc = cyc + 1;
                m_req_cyc   = cyc + 1;
            end else if (exp_req && mem_ack) begin
                if (!m_addr_phase) begin
                    b    = mem[m_pc];
                    m_pc = m_pc + 8'd1;
                    if (b[7:4] <= 4'd8) begin
                        m_exp_opc = b[7:4];
                        m_exp_opd = b[3:0];
                        m_op_cyc  = cyc + 2;
                        m_req_cyc = cyc + 2 + ExecCycles;
                    end else if (b[7:4] == 4'd9 || b[7:4] == 4'd10) begin
                        m_addr_phase = 1'b1;
                        m_is_jz      = (b[7:4] == 4'd10);
                        m_req_cyc    = cyc + 2;
                    end else if (b[7:4] == 4'd15) begin
                        m_halt_cyc = cyc + 2;
                        m_req_cyc  = Never;
                    end else begin
                        m_ill_cyc = cyc + 1;
                        m_req_cyc = cyc + 2;
                    end
                end else begin
                    m_addr_phase = 1'b0;
                    if (!m_is_jz || zero_flag) m_pc = mem[m_pc];
                    else                       m_pc = m_pc + 8'd1;
                    m_req_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        start  = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic run_prog(input int max_cyc, input bit until_halt);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (until_halt && halted === 1'b1) break;
            @(posedge clk);
            #1 start = ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        if (until_halt) check("halt_reached", 32'(halted), 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with start asserted.
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_op", 32'(op), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        start = 1'b0;

        // Two ALU ops then HLT, ack in the request cycle.
        fill_mem(8'hF0);
        mem[0] = 8'h15; mem[1] = 8'h33; mem[2] = 8'hFF;
        ack_pct = 100;
        apply_reset();
        run_prog(200, 1'b1);
        check("t2_nops", 32'(ops_q.size()), 32'd2);
        if (ops_q.size() == 2) begin
            check("t2_op0", 32'(ops_q[0]), 32'h15);
            check("t2_op1", 32'(ops_q[1]), 32'h33);
            // Execution window, then one fetch cycle and one decode cycle.
            check("t2_gap", 32'(op_cyc_q[1] - op_cyc_q[0]), 32'(ExecCycles + 2));
        end
        check("t2_pc", 32'(pc), 32'h3);

        // JMP over the address byte.
        fill_mem(8'hF0);
        mem[0] = 8'h90; mem[1] = 8'h10; mem[8'h10] = 8'h80;
        apply_reset();
        run_prog(200, 1'b1);
        check("t3_nops", 32'(ops_q.size()), 32'd1);
        if (ops_q.size() == 1) check("t3_op", 32'(ops_q[0]), 32'h80);
        check("t3_nfetch", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() == 4) check("t3_target", 32'(addr_q[2]), 32'h10);
        check("t3_pc", 32'(pc), 32'h12);

        // JZ taken and not taken.
        for (int zf = 1; zf >= 0; zf--) begin
            fill_mem(8'hF0);
            mem[0] = 8'hA0; mem[1] = 8'h20;
            zf_mode = zf;
            apply_reset();
            run_prog(200, 1'b1);
            check(zf ? "t4_pc_taken" : "t4_pc_fall", 32'(pc), zf ? 32'h21 : 32'h3);
        end
        zf_mode = 2;

        // Slow memory and an undefined opcode.
        fill_mem(8'hF0);
        mem[0] = 8'hB0;
        ack_delay = 3;
        apply_reset();
        run_prog(200, 1'b1);
        check("t5_illegal", 32'(n_ill), 32'd1);
        check("t5_nops", 32'(ops_q.size()), 32'd0);
        check("t5_pc", 32'(pc), 32'h2);
        ack_delay = -1;

        // PC wrap at 0xFF, then reset in the middle of a handshake.
        fill_mem(8'hF0);
        mem[0] = 8'h90; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
        apply_reset();
        run_prog(30, 1'b0);
        check("t6_nfetch", 32'(addr_q.size() >= 4), 32'd1);
        if (addr_q.size() >= 4) begin
            check("t6_ff", 32'(addr_q[2]), 32'hFF);
            check("t6_wrap", 32'(addr_q[3]), 32'h00);
        end
        ack_pct = 0;
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("t6_req_held", 32'(mem_req), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_req", 32'(mem_req), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_pc", 32'(pc), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        ack_pct = 100;

        // Random programs, latencies and zero flag.
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < 256; i++) begin
                b = 8'($urandom);
                if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'($urandom_range(0, 8));
                mem[i] = b;
            end
            ack_pct   = $urandom_range(25, 100);
            ack_delay = (it % 4 == 3) ? $urandom_range(0, 4) : -1;
            apply_reset();
            run_prog(300, 1'b0);
        end
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
